// File: rtl/cache_snoop_ctrl.sv
// cache_snoop_ctrl: MOESI bus-snoop handler for one tag array.
// Looks up a snooped line, downgrades it and returns a bus response.
module cache_snoop_ctrl #(
  parameter int SETS       = 128,
  parameter int WAYS       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = ADDR_WIDTH - $clog2(SETS) - 6,
  parameter int LRU_BITS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           snoop_valid,
  output logic                           snoop_ready,
  input  logic [ADDR_WIDTH-1:0]          snoop_addr,
  input  logic [1:0]                     snoop_type,
  output logic [$clog2(SETS)-1:0]        snoop_read_set,
  input  logic [WAYS-1:0][TAG_WIDTH-1:0] snoop_read_tags,
  input  logic [WAYS-1:0]                snoop_read_valids,
  input  logic [WAYS-1:0][2:0]           snoop_read_states,
  input  logic [WAYS-1:0][LRU_BITS-1:0]  snoop_read_lru,
  output logic                           tag_wr_req,
  input  logic                           tag_wr_gnt,
  output logic [$clog2(SETS)-1:0]        tag_wr_set,
  output logic [$clog2(WAYS)-1:0]        tag_wr_way,
  output logic [TAG_WIDTH-1:0]           tag_wr_tag,
  output logic                           tag_wr_valid,
  output logic [2:0]                     tag_wr_state,
  output logic [LRU_BITS-1:0]            tag_wr_lru,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic                           resp_supply,
  output logic                           resp_shared,
  output logic                           resp_err,
  output logic [$clog2(WAYS)-1:0]        resp_way
);

  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int OW = 6;

  localparam logic [2:0] ST_I = 3'b000;
  localparam logic [2:0] ST_M = 3'b001;
  localparam logic [2:0] ST_O = 3'b010;
  localparam logic [2:0] ST_E = 3'b100;
  localparam logic [2:0] ST_S = 3'b101;

  localparam logic [1:0] T_RD   = 2'b00;
  localparam logic [1:0] T_RDX  = 2'b01;
  localparam logic [1:0] T_UPGR = 2'b10;
  localparam logic [1:0] T_RSV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic                 rdy_en_q;
  logic [SW-1:0]        set_q;
  logic [TAG_WIDTH-1:0] stag_q;
  logic [1:0]           type_q;

  logic                 hit_q;
  logic [WW-1:0]        way_q;
  logic [2:0]           old_q;
  logic [2:0]           nxt_q;
  logic [TAG_WIDTH-1:0] ltag_q;
  logic [LRU_BITS-1:0]  lru_q;
  logic                 sup_q;
  logic                 shr_q;
  logic                 err_q;

  logic                 accept;
  logic [WAYS-1:0]      hit_vec;
  logic                 lk_any;
  logic                 lk_hit;
  logic                 lk_multi;
  logic [WW-1:0]        lk_way;
  logic [2:0]           lk_old;
  logic [2:0]           lk_nxt;
  logic [TAG_WIDTH-1:0] lk_tag;
  logic [LRU_BITS-1:0]  lk_lru;
  logic                 lk_sup;
  logic                 lk_bad;
  logic                 lk_legal;
  logic                 unused_offset;

  assign unused_offset = ^{snoop_addr[OW-1:0], old_q};

  assign snoop_ready    = (state_q == IDLE) && rdy_en_q;
  assign accept         = snoop_ready && snoop_valid;
  assign snoop_read_set = set_q;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = snoop_read_valids[w] &&
                   (snoop_read_states[w] != ST_I) &&
                   (snoop_read_tags[w] == stag_q);
    end
  end

  // lowest-index hitting way wins
  always_comb begin
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) lk_way = WW'(w);
    end
  end

  assign lk_any   = |hit_vec;
  assign lk_multi = |(hit_vec & (hit_vec - WAYS'(1)));
  assign lk_hit   = lk_any && (type_q != T_RSV);
  assign lk_old   = snoop_read_states[lk_way];
  assign lk_tag   = snoop_read_tags[lk_way];
  assign lk_lru   = snoop_read_lru[lk_way];
  assign lk_legal = (lk_old == ST_M) || (lk_old == ST_O) ||
                    (lk_old == ST_E) || (lk_old == ST_S);

  always_comb begin
    lk_nxt = lk_old;
    lk_sup = 1'b0;
    lk_bad = 1'b0;
    unique case (1'b1)
      type_q == T_RD: begin
        case (lk_old)
          ST_M: begin
            lk_nxt = ST_O;
            lk_sup = 1'b1;
          end
          ST_O: lk_sup = 1'b1;
          ST_E: lk_nxt = ST_S;
          ST_S: lk_nxt = ST_S;
          default: lk_bad = 1'b1;
        endcase
      end
      type_q == T_RDX: begin
        lk_nxt = ST_I;
        lk_sup = (lk_old == ST_M) || (lk_old == ST_O);
        lk_bad = !lk_legal;
      end
      type_q == T_UPGR: begin
        lk_nxt = ST_I;
        lk_bad = !((lk_old == ST_S) || (lk_old == ST_O));
      end
      default: begin
        lk_nxt = lk_old;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (lk_hit && (lk_nxt != lk_old)) state_d = WRITE;
        else state_d = RESP;
      end
      WRITE: begin
        if (tag_wr_gnt) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q  <= '0;
      stag_q <= '0;
      type_q <= '0;
    end else if (accept) begin
      set_q  <= snoop_addr[SW+OW-1:OW];
      stag_q <= snoop_addr[ADDR_WIDTH-1:SW+OW];
      type_q <= snoop_type;
    end
  end

  // a miss or reserved type leaves every result field at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      way_q  <= '0;
      old_q  <= ST_I;
      nxt_q  <= ST_I;
      ltag_q <= '0;
      lru_q  <= '0;
      sup_q  <= 1'b0;
      shr_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == LOOKUP) begin
      hit_q  <= lk_hit;
      way_q  <= lk_hit ? lk_way : '0;
      old_q  <= lk_hit ? lk_old : ST_I;
      nxt_q  <= lk_hit ? lk_nxt : ST_I;
      ltag_q <= lk_hit ? lk_tag : '0;
      lru_q  <= lk_hit ? lk_lru : '0;
      sup_q  <= lk_hit && lk_sup;
      shr_q  <= lk_hit && (lk_nxt != ST_I);
      err_q  <= lk_hit && (lk_multi || lk_bad);
    end
  end

  assign tag_wr_req   = (state_q == WRITE);
  assign tag_wr_set   = tag_wr_req ? set_q : '0;
  assign tag_wr_way   = tag_wr_req ? way_q : '0;
  assign tag_wr_tag   = tag_wr_req ? ltag_q : '0;
  assign tag_wr_valid = tag_wr_req && (nxt_q != ST_I);
  assign tag_wr_state = tag_wr_req ? nxt_q : ST_I;
  assign tag_wr_lru   = tag_wr_req ? lru_q : '0;

  assign resp_valid  = (state_q == RESP);
  assign resp_hit    = resp_valid && hit_q;
  assign resp_supply = resp_valid && sup_q;
  assign resp_shared = resp_valid && shr_q;
  assign resp_err    = resp_valid && err_q;
  assign resp_way    = resp_valid ? way_q : '0;

endmodule

// File: tb/tb_cache_snoop_ctrl.sv
// tb_cache_snoop_ctrl: directed and randomized snoops against
// a MOESI reference model and a bench-owned tag array.
`timescale 1ns/1ps
module tb_cache_snoop_ctrl;

  localparam int SETS = 128;
  localparam int WAYS = 4;
  localparam int TW   = 19;
  localparam int LB   = 2;

  localparam logic [2:0] I = 3'b000;
  localparam logic [2:0] M = 3'b001;
  localparam logic [2:0] O = 3'b010;
  localparam logic [2:0] E = 3'b100;
  localparam logic [2:0] S = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snoop_valid = 1'b0;
  logic snoop_ready;
  logic [31:0] snoop_addr = '0;
  logic [1:0] snoop_type = '0;
  logic [6:0] snoop_read_set;
  logic [WAYS-1:0][TW-1:0] snoop_read_tags;
  logic [WAYS-1:0] snoop_read_valids;
  logic [WAYS-1:0][2:0] snoop_read_states;
  logic [WAYS-1:0][LB-1:0] snoop_read_lru;
  logic tag_wr_req;
  logic tag_wr_gnt = 1'b0;
  logic [6:0] tag_wr_set;
  logic [1:0] tag_wr_way;
  logic [TW-1:0] tag_wr_tag;
  logic tag_wr_valid;
  logic [2:0] tag_wr_state;
  logic [LB-1:0] tag_wr_lru;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic resp_hit, resp_supply, resp_shared, resp_err;
  logic [1:0] resp_way;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cache_snoop_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
    .snoop_addr(snoop_addr), .snoop_type(snoop_type),
    .snoop_read_set(snoop_read_set),
    .snoop_read_tags(snoop_read_tags),
    .snoop_read_valids(snoop_read_valids),
    .snoop_read_states(snoop_read_states),
    .snoop_read_lru(snoop_read_lru),
    .tag_wr_req(tag_wr_req), .tag_wr_gnt(tag_wr_gnt),
    .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way),
    .tag_wr_tag(tag_wr_tag), .tag_wr_valid(tag_wr_valid),
    .tag_wr_state(tag_wr_state), .tag_wr_lru(tag_wr_lru),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_supply(resp_supply),
    .resp_shared(resp_shared), .resp_err(resp_err),
    .resp_way(resp_way)
  );

  logic [TW-1:0] a_tag [SETS][WAYS];
  logic          a_vld [SETS][WAYS];
  logic [2:0]    a_st  [SETS][WAYS];
  logic [LB-1:0] a_lru [SETS][WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_rd
    assign snoop_read_tags[w]   = a_tag[snoop_read_set][w];
    assign snoop_read_valids[w] = a_vld[snoop_read_set][w];
    assign snoop_read_states[w] = a_st[snoop_read_set][w];
    assign snoop_read_lru[w]    = a_lru[snoop_read_set][w];
  end

  typedef struct {
    logic hit;
    logic [1:0] way;
    logic supply, shared, err, wr;
    logic [2:0] nxt;
    logic [TW-1:0] tag;
    logic [LB-1:0] lru;
  } exp_t;

  typedef struct {
    bit timeout;
    int wr_n;
    bit wr_stable;
    int wr_first;
    logic [6:0] wr_set;
    logic [1:0] wr_way;
    logic [TW-1:0] wr_tag;
    logic wr_valid;
    logic [2:0] wr_state;
    logic [LB-1:0] wr_lru;
    int rsp_n;
    bit rsp_stable;
    int rsp_first;
    logic hit, supply, shared, err;
    logic [1:0] way;
    bit busy_ok;
    bit post_ok;
    bit zero_ok;
  } obs_t;

  // MOESI snoop rules applied to the bench's copy of the array
  function automatic exp_t model(input logic [31:0] a,
                                 input logic [1:0] t);
    exp_t e;
    int n, first, s;
    logic [2:0] old;
    e = '{default: 0};
    n = 0;
    first = -1;
    s = int'(a[12:6]);
    for (int w = 0; w < WAYS; w++) begin
      if (a_vld[s][w] && a_st[s][w] != I && a_tag[s][w] == a[31:13]) begin
        n++;
        if (first < 0) first = w;
      end
    end
    if (n == 0 || t == 2'b11) return e;
    old = a_st[s][first];
    e.hit = 1'b1;
    e.way = first[1:0];
    e.err = (n > 1);
    e.tag = a[31:13];
    e.lru = a_lru[s][first];
    case (t)
      2'b00: begin
        e.nxt = (old == M || old == O) ? O : S;
        e.supply = (old == M || old == O);
      end
      2'b01: begin
        e.nxt = I;
        e.supply = (old == M || old == O);
      end
      default: begin
        e.nxt = I;
        if (old == M || old == E) e.err = 1'b1;
      end
    endcase
    e.shared = (e.nxt != I);
    e.wr = (e.nxt != old);
    return e;
  endfunction

  task automatic clear_set(input int s);
    for (int w = 0; w < WAYS; w++) begin
      a_vld[s][w] = 1'b0;
      a_st[s][w]  = I;
      a_tag[s][w] = TW'($urandom);
      a_lru[s][w] = LB'($urandom);
    end
  endtask

  // drive one snoop; grant after gd req cycles, ready after rd resp cycles
  task automatic do_snoop(input logic [31:0] a, input logic [1:0] t,
                          input int gd, input int rd, output obs_t o);
    bit done, commit;
    int cyc;
    logic [6:0] cs;
    logic [1:0] cw;
    o = '{default: 0};
    o.wr_stable = 1; o.rsp_stable = 1;
    o.busy_ok = 1; o.zero_ok = 1;
    snoop_addr = a; snoop_type = t; snoop_valid = 1'b1;
    tag_wr_gnt = (gd == 0);
    resp_ready = (rd == 0);
    @(posedge clk); #1;
    cyc = 1;
    snoop_addr = $urandom;
    snoop_type = 2'($urandom);
    done = 0;
    while (!done && cyc < 60) begin
      if (snoop_ready) o.busy_ok = 0;
      if (tag_wr_req) begin
        o.wr_n++;
        if (o.wr_n == 1) begin
          o.wr_first = cyc;
          o.wr_set = tag_wr_set; o.wr_way = tag_wr_way;
          o.wr_tag = tag_wr_tag; o.wr_valid = tag_wr_valid;
          o.wr_state = tag_wr_state; o.wr_lru = tag_wr_lru;
        end else if ({tag_wr_set, tag_wr_way, tag_wr_tag, tag_wr_valid,
                      tag_wr_state, tag_wr_lru} !==
                     {o.wr_set, o.wr_way, o.wr_tag, o.wr_valid,
                      o.wr_state, o.wr_lru}) begin
          o.wr_stable = 0;
        end
        tag_wr_gnt = (o.wr_n > gd);
      end else if ({tag_wr_set, tag_wr_way, tag_wr_tag, tag_wr_valid,
                    tag_wr_state, tag_wr_lru} !== '0) begin
        o.zero_ok = 0;
      end
      if (resp_valid) begin
        o.rsp_n++;
        if (o.rsp_n == 1) begin
          o.rsp_first = cyc;
          o.hit = resp_hit; o.supply = resp_supply;
          o.shared = resp_shared; o.err = resp_err; o.way = resp_way;
        end else if ({resp_hit, resp_supply, resp_shared, resp_err, resp_way}
                     !== {o.hit, o.supply, o.shared, o.err, o.way}) begin
          o.rsp_stable = 0;
        end
        resp_ready = (o.rsp_n > rd);
        if (resp_ready) done = 1;
      end else if ({resp_hit, resp_supply, resp_shared, resp_err, resp_way}
                   !== '0) begin
        o.zero_ok = 0;
      end
      commit = tag_wr_req && tag_wr_gnt;
      cs = tag_wr_set;
      cw = tag_wr_way;
      if (commit) begin
        a_tag[cs][cw] = tag_wr_tag;
        a_vld[cs][cw] = tag_wr_valid;
        a_st[cs][cw]  = tag_wr_state;
        a_lru[cs][cw] = tag_wr_lru;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) o.timeout = 1;
    else o.post_ok = !resp_valid && snoop_ready && !tag_wr_req;
    snoop_valid = 1'b0;
    tag_wr_gnt = 1'b0;
    resp_ready = 1'b0;
    snoop_addr = '0;
    snoop_type = '0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < SETS; s++) clear_set(s);
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({snoop_ready, tag_wr_req, resp_valid, snoop_read_set} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %0h want 0",
               {snoop_ready, tag_wr_req, resp_valid, snoop_read_set});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (snoop_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_release_ready: got %b want 1", snoop_ready);
    end
  endtask

  task automatic test_m_busrd();
    obs_t o;
    clear_set(5);
    a_tag[5][2] = 19'h1ABCD; a_vld[5][2] = 1; a_st[5][2] = M; a_lru[5][2] = 2'b10;
    do_snoop({19'h1ABCD, 7'd5, 6'd0}, 2'b00, 0, 0, o);
    n_vec++;
    if ({o.timeout, o.wr_n, o.wr_set, o.wr_way, o.wr_tag, o.wr_valid,
         o.wr_state, o.wr_lru} !==
        {1'b0, 32'd1, 7'd5, 2'd2, 19'h1ABCD, 1'b1, O, 2'b10}) begin
      n_miss++;
      $display("FAIL m_busrd_write: got n=%0d set=%0d way=%0d tag=%0h v=%b st=%b want n=1 set=5 way=2 tag=1abcd v=1 st=010",
               o.wr_n, o.wr_set, o.wr_way, o.wr_tag, o.wr_valid, o.wr_state);
    end
    n_vec++;
    if ({o.hit, o.supply, o.shared, o.err, o.way} !== {4'b1110, 2'd2}) begin
      n_miss++;
      $display("FAIL m_busrd_resp: got %b want 111010",
               {o.hit, o.supply, o.shared, o.err, o.way});
    end
    n_vec++;
    if (o.rsp_first !== 3) begin
      n_miss++;
      $display("FAIL m_busrd_latency: got %0d want 3", o.rsp_first);
    end
    n_vec++;
    if ({o.busy_ok, o.post_ok, o.zero_ok} !== 3'b111) begin
      n_miss++;
      $display("FAIL m_busrd_handshake: got %b want 111",
               {o.busy_ok, o.post_ok, o.zero_ok});
    end
  endtask

  task automatic test_s_busrd();
    obs_t o;
    a_st[5][2] = S;
    do_snoop({19'h1ABCD, 7'd5, 6'd17}, 2'b00, 0, 0, o);
    n_vec++;
    if ({o.timeout, o.wr_n} !== {1'b0, 32'd0}) begin
      n_miss++;
      $display("FAIL s_busrd_nowrite: got to=%b n=%0d want to=0 n=0",
               o.timeout, o.wr_n);
    end
    n_vec++;
    if ({o.hit, o.supply, o.shared, o.err, o.way, o.rsp_first} !==
        {4'b1010, 2'd2, 32'd2}) begin
      n_miss++;
      $display("FAIL s_busrd_resp: got %b at %0d want 101010 at 2",
               {o.hit, o.supply, o.shared, o.err, o.way}, o.rsp_first);
    end
  endtask

  task automatic test_e_busrdx_stall();
    obs_t o;
    a_st[5][2] = E;
    do_snoop({19'h1ABCD, 7'd5, 6'd3}, 2'b01, 4, 0, o);
    n_vec++;
    if ({o.timeout, o.wr_n, o.wr_stable, o.wr_valid, o.wr_state} !==
        {1'b0, 32'd5, 1'b1, 1'b0, I}) begin
      n_miss++;
      $display("FAIL rdx_stall_write: got n=%0d stable=%b v=%b st=%b want n=5 stable=1 v=0 st=000",
               o.wr_n, o.wr_stable, o.wr_valid, o.wr_state);
    end
    n_vec++;
    if ({o.hit, o.supply, o.shared, o.err, o.rsp_first} !==
        {4'b1000, 32'd7}) begin
      n_miss++;
      $display("FAIL rdx_stall_resp: got %b at %0d want 1000 at 7",
               {o.hit, o.supply, o.shared, o.err}, o.rsp_first);
    end
    n_vec++;
    if ({a_vld[5][2], a_st[5][2]} !== {1'b0, I}) begin
      n_miss++;
      $display("FAIL rdx_stall_array: got %b want 0000",
               {a_vld[5][2], a_st[5][2]});
    end
  endtask

  task automatic test_upgr_m();
    obs_t o;
    clear_set(33);
    a_tag[33][1] = 19'h00777; a_vld[33][1] = 1; a_st[33][1] = M;
    do_snoop({19'h00777, 7'd33, 6'd9}, 2'b10, 0, 0, o);
    n_vec++;
    if ({o.timeout, o.wr_n, o.wr_way, o.wr_state, o.wr_valid} !==
        {1'b0, 32'd1, 2'd1, I, 1'b0}) begin
      n_miss++;
      $display("FAIL upgr_m_write: got n=%0d way=%0d st=%b v=%b want n=1 way=1 st=000 v=0",
               o.wr_n, o.wr_way, o.wr_state, o.wr_valid);
    end
    n_vec++;
    if ({o.hit, o.supply, o.shared, o.err} !== 4'b1001) begin
      n_miss++;
      $display("FAIL upgr_m_resp: got %b want 1001",
               {o.hit, o.supply, o.shared, o.err});
    end
  endtask

  task automatic test_miss_and_reserved();
    obs_t o;
    clear_set(9);
    do_snoop({19'h2F00F, 7'd9, 6'd0}, 2'b00, 0, 3, o);
    n_vec++;
    if ({o.timeout, o.wr_n, o.rsp_n, o.rsp_stable, o.busy_ok, o.post_ok} !==
        {1'b0, 32'd0, 32'd4, 3'b111}) begin
      n_miss++;
      $display("FAIL miss_invalid_hold: got n_wr=%0d n_rsp=%0d st=%b busy=%b post=%b want 0 4 1 1 1",
               o.wr_n, o.rsp_n, o.rsp_stable, o.busy_ok, o.post_ok);
    end
    n_vec++;
    if ({o.hit, o.supply, o.shared, o.err, o.way} !== '0) begin
      n_miss++;
      $display("FAIL miss_invalid_resp: got %b want 0",
               {o.hit, o.supply, o.shared, o.err, o.way});
    end
    a_tag[9][0] = 19'h2F00E; a_vld[9][0] = 1; a_st[9][0] = M;
    do_snoop({19'h2F00F, 7'd9, 6'd0}, 2'b01, 0, 1, o);
    n_vec++;
    if ({o.timeout, o.wr_n, o.hit, o.rsp_first} !==
        {1'b0, 32'd0, 1'b0, 32'd2}) begin
      n_miss++;
      $display("FAIL miss_tag: got n_wr=%0d hit=%b at %0d want 0 0 at 2",
               o.wr_n, o.hit, o.rsp_first);
    end
    do_snoop({19'h2F00E, 7'd9, 6'd0}, 2'b11, 0, 3, o);
    n_vec++;
    if ({o.timeout, o.wr_n, o.hit, o.err, o.supply, o.rsp_n, o.busy_ok} !==
        {1'b0, 32'd0, 3'b000, 32'd4, 1'b1}) begin
      n_miss++;
      $display("FAIL reserved_type: got n_wr=%0d hit=%b err=%b n_rsp=%0d busy=%b want 0 0 0 4 1",
               o.wr_n, o.hit, o.err, o.rsp_n, o.busy_ok);
    end
  endtask

  task automatic test_multi_hit();
    obs_t o;
    clear_set(77);
    a_tag[77][1] = 19'h05A5A; a_vld[77][1] = 1; a_st[77][1] = S;
    a_tag[77][3] = 19'h05A5A; a_vld[77][3] = 1; a_st[77][3] = S;
    do_snoop({19'h05A5A, 7'd77, 6'd1}, 2'b01, 1, 0, o);
    n_vec++;
    if ({o.timeout, o.hit, o.err, o.way, o.wr_way} !==
        {3'b011, 2'd1, 2'd1}) begin
      n_miss++;
      $display("FAIL multi_hit: got hit=%b err=%b way=%0d wr_way=%0d want 1 1 1 1",
               o.hit, o.err, o.way, o.wr_way);
    end
    n_vec++;
    if ({a_st[77][1], a_st[77][3]} !== {I, S}) begin
      n_miss++;
      $display("FAIL multi_hit_array: got %b want 000101",
               {a_st[77][1], a_st[77][3]});
    end
  endtask

  task automatic test_reset_in_write();
    bit bad;
    clear_set(20);
    a_tag[20][0] = 19'h13579; a_vld[20][0] = 1; a_st[20][0] = E;
    snoop_addr = {19'h13579, 7'd20, 6'd0};
    snoop_type = 2'b01;
    snoop_valid = 1'b1;
    tag_wr_gnt = 1'b0;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (tag_wr_req !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_write_entry: got req=%b want 1", tag_wr_req);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({tag_wr_req, resp_valid, snoop_ready, tag_wr_state} !== '0) begin
      n_miss++;
      $display("FAIL rst_write_abort: got %b want 0",
               {tag_wr_req, resp_valid, snoop_ready, tag_wr_state});
    end
    tag_wr_gnt = 1'b1;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (snoop_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_write_ready: got %b want 1", snoop_ready);
    end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (tag_wr_req || resp_valid) bad = 1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_write_residue: got activity=%b want 0", bad);
    end
    tag_wr_gnt = 1'b0;
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] sts [5];
    logic [TW-1:0] ts [3];
    logic [TW-1:0] tb;
    logic [31:0] a;
    logic [1:0] t;
    int s, gd, rd, lat;
    exp_t e;
    obs_t o;
    sts = '{M, O, E, S, I};
    for (int it = 0; it < 60; it++) begin
      s = $urandom_range(0, 13) * 9;
      tb = TW'($urandom);
      ts = '{tb, tb ^ 19'h1, tb ^ 19'h2};
      for (int w = 0; w < WAYS; w++) begin
        a_tag[s][w] = ts[$urandom_range(0, 2)];
        a_vld[s][w] = 1'($urandom);
        a_st[s][w]  = sts[$urandom_range(0, 4)];
        a_lru[s][w] = LB'($urandom);
      end
      a = {ts[$urandom_range(0, 2)], s[6:0], 6'($urandom)};
      t = 2'($urandom);
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      e = model(a, t);
      do_snoop(a, t, gd, rd, o);
      n_vec++;
      if ({o.timeout, o.hit, o.way, o.supply, o.shared, o.err} !==
          {1'b0, e.hit, e.way, e.supply, e.shared, e.err}) begin
        n_miss++;
        $display("FAIL rand_resp[%0d]: a=%h t=%0d got to=%b %b want %b",
                 it, a, t, o.timeout,
                 {o.hit, o.way, o.supply, o.shared, o.err},
                 {e.hit, e.way, e.supply, e.shared, e.err});
      end
      n_vec++;
      if ((o.wr_n != 0) !== e.wr) begin
        n_miss++;
        $display("FAIL rand_wr_issue[%0d]: got n=%0d want wr=%b",
                 it, o.wr_n, e.wr);
      end
      if (e.wr) begin
        n_vec++;
        if ({o.wr_set, o.wr_way, o.wr_tag, o.wr_valid, o.wr_state,
             o.wr_lru, o.wr_n, o.wr_stable} !==
            {s[6:0], e.way, e.tag, e.nxt != I, e.nxt, e.lru,
             gd + 1, 1'b1}) begin
          n_miss++;
          $display("FAIL rand_wr_fields[%0d]: got way=%0d tag=%h st=%b lru=%0d n=%0d want way=%0d tag=%h st=%b lru=%0d n=%0d",
                   it, o.wr_way, o.wr_tag, o.wr_state, o.wr_lru, o.wr_n,
                   e.way, e.tag, e.nxt, e.lru, gd + 1);
        end
      end
      lat = e.wr ? 3 + gd : 2;
      n_vec++;
      if ({o.rsp_first, o.rsp_n} !== {lat, rd + 1}) begin
        n_miss++;
        $display("FAIL rand_timing[%0d]: got lat=%0d n=%0d want lat=%0d n=%0d",
                 it, o.rsp_first, o.rsp_n, lat, rd + 1);
      end
      n_vec++;
      if ({o.rsp_stable, o.busy_ok, o.post_ok, o.zero_ok} !== 4'b1111) begin
        n_miss++;
        $display("FAIL rand_protocol[%0d]: got %b want 1111", it,
                 {o.rsp_stable, o.busy_ok, o.post_ok, o.zero_ok});
      end
    end
  endtask

  initial begin
    test_reset();
    test_m_busrd();
    test_s_busrd();
    test_e_busrdx_stall();
    test_upgr_m();
    test_miss_and_reserved();
    test_multi_hit();
    test_reset_in_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cache_snoop_ctrl.md
CACHE_SNOOP_CTRL -- requirements
Module: cache_snoop_ctrl

Interface
REQ-001 Parameters SHALL be: SETS 128, sets per cache; WAYS 4, associativity; ADDR_WIDTH 32, physical address bits; TAG_WIDTH ADDR_WIDTH-$clog2(SETS)-6, tag bits for a 64B line; LRU_BITS 2, per-way LRU field.
REQ-002 clk  in  1  clock; reset rst_n, asynchronous, active-low; all state SHALL be updated on the rising edge of clk.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 snoop_valid  in  1  incoming bus snoop request valid.
REQ-005 snoop_ready  out  1  block can accept a snoop.
REQ-006 snoop_addr  in  ADDR_WIDTH  snooped address: offset [5:0], set [12:6], tag [31:13].
REQ-007 snoop_type  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved.
REQ-008 snoop_read_set  out  $clog2(SETS)  set index to the tag array snoop read port.
REQ-009 snoop_read_tags / _valids / _states / _lru  in  WAYS x TAG_WIDTH / WAYS / WAYS x 3 / WAYS x LRU_BITS  combinational tag-array read data for snoop_read_set.
REQ-010 tag_wr_req  out  1  request for the tag-array write port.
REQ-011 tag_wr_gnt  in  1  write port granted; the array commits at the same clk edge.
REQ-012 tag_wr_set, tag_wr_way, tag_wr_tag, tag_wr_valid, tag_wr_state, tag_wr_lru  out  7, 2, TAG_WIDTH, 1, 3, LRU_BITS  write fields.
REQ-013 resp_valid  out  1; resp_ready  in  1  snoop response handshake.
REQ-014 resp_hit, resp_supply, resp_shared, resp_err  out  1 each; resp_way  out  2  response fields.

Function
REQ-015 MOESI encoding SHALL be M=001, O=010, E=100, S=101, I=000. A way SHALL hit when valid=1, state!=I, and tag equals snoop_addr[31:13].
REQ-016 FSM states SHALL be IDLE, LOOKUP, WRITE, RESP. snoop_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on snoop_valid=1, the block SHALL register addr and type and go to LOOKUP.
REQ-018 snoop_read_set SHALL always be driven from the registered address bits [12:6].
REQ-019 LOOKUP SHALL last exactly 1 cycle and register hit, way, old state, next state, tag and lru. Among multiple hit ways it SHALL pick the lowest-index way and set resp_err.
REQ-020 Next state and supply SHALL follow this table:
  - BusRd: M->O supply=1; O->O supply=1; E->S; S->S.
  - BusRdX: M->I supply=1; O->I supply=1; E->I; S->I.
  - BusUpgr: S->I; O->I; M or E->I with resp_err=1; supply=0.
  - Type 11: no lookup result used, hit=0, no write.
REQ-021 resp_shared SHALL be 1 when the hit line's next state is not I.
REQ-022 After LOOKUP the FSM SHALL go to WRITE if hit and next state differs from old state, else to RESP.
REQ-023 WRITE SHALL hold tag_wr_req=1 with stable fields until tag_wr_gnt=1:
  - tag_wr_tag = registered tag; tag_wr_lru = registered lru of that way (unchanged).
  - tag_wr_state = next state; tag_wr_valid = (next state != I).
  - On gnt the FSM SHALL go to RESP.
REQ-024 RESP SHALL hold resp_valid=1 with stable fields until resp_ready=1, then go to IDLE; a new snoop SHALL NOT be accepted in that same cycle.
REQ-025 Minimum latency from accept edge to resp_valid SHALL be 2 cycles on the no-write path and 3 cycles on the write path with immediate gnt.
REQ-026 Response fields SHALL be 0 and tag_wr_* fields SHALL be 0 whenever the corresponding valid/req is 0.

Reset
REQ-027 While rst_n=0:
  - FSM SHALL be IDLE.
  - snoop_ready, tag_wr_req and resp_valid SHALL be 0; snoop_read_set and all registered fields SHALL be 0.
  - snoop_ready SHALL rise in the first cycle after deassertion.
REQ-028 Reset asserted in LOOKUP, WRITE or RESP SHALL abandon the snoop immediately. No tag write SHALL issue afterwards, and no response for it SHALL be produced.

Verification
REQ-029 Set 5 way 2 holds tag 0x1ABCD in M; BusRd to addr {0x1ABCD,7'd5,6'd0}, gnt and ready held high -> write way 2 state O, valid 1; resp hit=1 supply=1 shared=1 way=2 at cycle 3.
REQ-030 Same line in S; BusRd -> no tag_wr_req; resp hit=1 supply=0 shared=1 at cycle 2.
REQ-031 Line in E; BusRdX; gnt held low 4 cycles -> tag_wr_req and its fields stable for 5 cycles, then write state I, valid 0; resp hit=1 shared=0.
REQ-032 BusUpgr hitting M -> write state I; resp_err=1, supply=0.
REQ-033 Miss (all ways I or tag mismatch) and type 11 -> no write; resp hit=0; resp_ready held low 3 cycles -> resp stable; snoop_ready=0 throughout.
REQ-034 rst_n pulsed low while in WRITE -> tag_wr_req=0 immediately, no response; snoop_ready=1 after release.
